// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle MIPS control FSM: opcodes, states, datapath select encodings.
// MC_CTRL_BNE_EN adds the bne opcode and its branch-not-equal state.
package mc_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_BNEST  = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG      = 2'b00,
        SRCB_FOUR     = 2'b01,
        SRCB_SEXT     = 2'b10,
        SRCB_SEXT_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       branch;
`ifdef MC_CTRL_BNE_EN
        logic       branch_ne;
`endif
        logic       iord;
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_src_t    pc_src;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic ctrl_word_t ctrl_idle();
        ctrl_word_t c;
        c.ir_write   = 1'b0;
        c.pc_write   = 1'b0;
        c.branch     = 1'b0;
`ifdef MC_CTRL_BNE_EN
        c.branch_ne  = 1'b0;
`endif
        c.iord       = 1'b0;
        c.mem_req    = 1'b0;
        c.mem_write  = 1'b0;
        c.reg_write  = 1'b0;
        c.reg_dst    = 1'b0;
        c.mem_to_reg = 1'b0;
        c.alu_src_a  = 1'b0;
        c.alu_src_b  = SRCB_REG;
        c.alu_op     = ALU_ADD;
        c.pc_src     = PCSRC_ALU;
        c.illegal_op = 1'b0;
        return c;
    endfunction

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
`ifdef MC_CTRL_BNE_EN
            OP_BNE:                                        legal = 1'b1;
`endif
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
// MC_CTRL_BNE_EN adds branch_ne; pc_en is the datapath's combined PC load enable.
interface mc_ctrl_fsm_if;
    import mc_ctrl_pkg::*;

    logic [OP_W-1:0] op;
    logic            zero;
    logic            mem_ready;
    logic            ir_write;
    logic            pc_write;
    logic            branch;
`ifdef MC_CTRL_BNE_EN
    logic            branch_ne;
`endif
    logic            iord;
    logic            mem_req;
    logic            mem_write;
    logic            reg_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [1:0]      pc_src;
    logic            illegal_op;
    logic            pc_en;

`ifdef MC_CTRL_BNE_EN
    assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
    assign pc_en = pc_write | (branch & zero);
`endif

    modport master (
        input  op, zero, mem_ready,
        output ir_write, pc_write, branch,
`ifdef MC_CTRL_BNE_EN
        output branch_ne,
`endif
        output iord, mem_req, mem_write, reg_write, reg_dst, mem_to_reg,
        output alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  ir_write, pc_write, branch,
`ifdef MC_CTRL_BNE_EN
        input  branch_ne,
`endif
        input  iord, mem_req, mem_write, reg_write, reg_dst, mem_to_reg,
        input  alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, pc_en
    );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decoder for the multicycle FSM.
// MC_CTRL_BNE_EN enables decoding of the BNEST state.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t          i_state,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_mem_ready,
    input  logic            i_rst_n,
    output ctrl_word_t      o_ctrl
);

    ctrl_word_t w_raw;

    // Per-state control pattern; unknown encodings leave everything idle.
    always_comb begin
        w_raw = ctrl_idle();
        unique case (i_state)
            S_FETCH: begin
                w_raw.mem_req   = 1'b1;
                w_raw.alu_src_b = SRCB_FOUR;
                w_raw.ir_write  = i_mem_ready;
                w_raw.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                w_raw.alu_src_b  = SRCB_SEXT_SH2;
                w_raw.illegal_op = ~op_is_legal(i_op);
            end
            S_MEMADR, S_ADDIEX: begin
                w_raw.alu_src_a = 1'b1;
                w_raw.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                w_raw.mem_req = 1'b1;
                w_raw.iord    = 1'b1;
            end
            S_MEMWB: begin
                w_raw.reg_write  = 1'b1;
                w_raw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_raw.mem_req   = 1'b1;
                w_raw.mem_write = 1'b1;
                w_raw.iord      = 1'b1;
            end
            S_EXEC: begin
                w_raw.alu_src_a = 1'b1;
                w_raw.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                w_raw.reg_write = 1'b1;
                w_raw.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_raw.alu_src_a = 1'b1;
                w_raw.alu_op    = ALU_SUB;
                w_raw.branch    = 1'b1;
                w_raw.pc_src    = PCSRC_ALUOUT;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNEST: begin
                w_raw.alu_src_a = 1'b1;
                w_raw.alu_op    = ALU_SUB;
                w_raw.branch_ne = 1'b1;
                w_raw.pc_src    = PCSRC_ALUOUT;
            end
`endif
            S_ADDIWB: begin
                w_raw.reg_write = 1'b1;
            end
            S_JUMP: begin
                w_raw.pc_write = 1'b1;
                w_raw.pc_src   = PCSRC_JUMP;
            end
            default: begin
                w_raw = ctrl_idle();
            end
        endcase
    end

    // Reset gates the write enables immediately, without waiting for a clock.
    always_comb begin
        o_ctrl           = w_raw;
        o_ctrl.ir_write  = w_raw.ir_write  & i_rst_n;
        o_ctrl.pc_write  = w_raw.pc_write  & i_rst_n;
        o_ctrl.reg_write = w_raw.reg_write & i_rst_n;
        o_ctrl.mem_req   = w_raw.mem_req   & i_rst_n;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register and next-state logic only.
// MC_CTRL_BNE_EN adds the bne instruction (DECODE -> BNEST) and the branch_ne output.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_fsm_if.master bus
);

    state_t     r_state;
    ctrl_word_t w_ctrl;

    // State register; memory states wait on mem_ready, others advance every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            unique case (r_state)
                S_FETCH:  r_state <= bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
`ifdef MC_CTRL_BNE_EN
                        OP_BNE:       r_state <= S_BNEST;
`endif
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= bus.mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  r_state <= bus.mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_op        (bus.op),
        .i_mem_ready (bus.mem_ready),
        .i_rst_n     (rst_n),
        .o_ctrl      (w_ctrl)
    );

    assign bus.ir_write   = w_ctrl.ir_write;
    assign bus.pc_write   = w_ctrl.pc_write;
    assign bus.branch     = w_ctrl.branch;
`ifdef MC_CTRL_BNE_EN
    assign bus.branch_ne  = w_ctrl.branch_ne;
`endif
    assign bus.iord       = w_ctrl.iord;
    assign bus.mem_req    = w_ctrl.mem_req;
    assign bus.mem_write  = w_ctrl.mem_write;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.pc_src     = w_ctrl.pc_src;
    assign bus.illegal_op = w_ctrl.illegal_op;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle control words checked against hand-written patterns.
// Build with MC_CTRL_BNE_EN defined to exercise bne instead of its illegal-opcode case.
module tb_mc_ctrl_fsm;

    // {ir_write, pc_write, branch, iord, mem_req, mem_write, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], illegal_op}
    localparam logic [16:0] E_FETCH   = 17'b1_1_0_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH_W = 17'b0_0_0_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_RST     = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] E_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEMRD   = 17'b0_0_0_1_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] E_MEMWR   = 17'b0_0_0_1_1_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_ALUWB   = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
    localparam logic [16:0] E_BRANCH  = 17'b0_0_1_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] E_ADDIWB  = 17'b0_0_0_0_0_0_1_0_0_0_00_00_00_0;
    localparam logic [16:0] E_JUMP    = 17'b0_1_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] E_BNEST   = 17'b0_0_0_0_0_0_0_0_0_1_00_01_01_0;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_BAD   = 6'b111111;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [16:0] obs = {bus.ir_write, bus.pc_write, bus.branch, bus.iord, bus.mem_req,
                       bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                       bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_RST) begin
                errors++;
                $display("FAIL reset cyc%0d got %b want %b", i, obs, E_RST);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [16:0] want [5];
        want = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        bus.op = T_LW;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL lw cyc%0d got %b want %b", i, obs, want[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        logic [16:0] want [7];
        logic        mr   [7];
        want = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR};
        mr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.op = T_SW;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL sw_stall cyc%0d got %b want %b", i, obs, want[i]);
            end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_beq();
        logic [16:0] want [3];
        want = '{E_FETCH, E_DECODE, E_BRANCH};
        bus.op = T_BEQ;
        bus.mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== want[i]) begin
                    errors++;
                    $display("FAIL beq z%0d cyc%0d got %b want %b", z, i, obs, want[i]);
                end
                if (i == 2) begin
                    checks++;
                    if (bus.pc_en !== z[0]) begin
                        errors++;
                        $display("FAIL beq_pc_en z%0d got %b want %b", z, bus.pc_en, z[0]);
                    end
                end
                @(posedge clk); #1;
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_rtype_addi();
        logic [16:0] want [9];
        logic        mr   [9];
        logic [5:0]  opv  [9];
        want = '{E_FETCH_W, E_FETCH, E_DECODE, E_EXEC, E_ALUWB,
                 E_FETCH, E_DECODE, E_MEMADR, E_ADDIWB};
        mr   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opv  = '{T_RTYPE, T_RTYPE, T_RTYPE, T_RTYPE, T_RTYPE, T_ADDI, T_ADDI, T_ADDI, T_ADDI};
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = mr[i];
            bus.op = opv[i];
            @(negedge clk);
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL rtype_addi cyc%0d got %b want %b", i, obs, want[i]);
            end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_jump();
        logic [16:0] want [3];
        want = '{E_FETCH, E_DECODE, E_JUMP};
        bus.op = T_J;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL jump cyc%0d got %b want %b", i, obs, want[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [16:0] want [2];
        logic [5:0]  bad  [2];
        want = '{E_FETCH, E_DEC_ILL};
`ifdef MC_CTRL_BNE_EN
        bad  = '{T_BAD, T_BAD};
`else
        bad  = '{T_BAD, T_BNE};
`endif
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.op = bad[k];
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== want[i]) begin
                    errors++;
                    $display("FAIL illegal op%b cyc%0d got %b want %b", bad[k], i, obs, want[i]);
                end
                @(posedge clk); #1;
            end
        end
        // The illegal opcode must return straight to FETCH.
        bus.op = T_J;
        @(negedge clk);
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL illegal_return got %b want %b", obs, E_FETCH);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

`ifdef MC_CTRL_BNE_EN
    task automatic test_bne();
        logic [16:0] want [3];
        want = '{E_FETCH, E_DECODE, E_BNEST};
        bus.op = T_BNE;
        bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL bne cyc%0d got %b want %b", i, obs, want[i]);
            end
            if (i == 2) begin
                checks++;
                if ({bus.branch_ne, bus.pc_en} !== 2'b11) begin
                    errors++;
                    $display("FAIL bne_pc_en got %b%b want 11", bus.branch_ne, bus.pc_en);
                end
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_reset_mid_memrd();
        logic [16:0] pre  [3];
        logic [16:0] post [5];
        pre  = '{E_FETCH, E_DECODE, E_MEMADR};
        post = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        bus.op = T_LW;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== pre[i]) begin
                errors++;
                $display("FAIL rst_mid pre cyc%0d got %b want %b", i, obs, pre[i]);
            end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_MEMRD) begin
            errors++;
            $display("FAIL rst_mid memrd got %b want %b", obs, E_MEMRD);
        end
        #2;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== E_RST) begin
            errors++;
            $display("FAIL rst_mid abort got %b want %b", obs, E_RST);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_RST) begin
                errors++;
                $display("FAIL rst_mid hold cyc%0d got %b want %b", i, obs, E_RST);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== post[i]) begin
                errors++;
                $display("FAIL rst_mid post cyc%0d got %b want %b", i, obs, post[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.op = T_RTYPE;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype_addi();
        test_jump();
`ifdef MC_CTRL_BNE_EN
        test_bne();
`endif
        test_illegal();
        test_reset_mid_memrd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control state machine for the multicycle MIPS core.
- Decodes the 6-bit opcode and sequences the shared datapath (PC, IR, register file, single ALU, unified memory port) through fetch/decode/execute/memory/writeback steps.
- Drives all datapath enables and mux selects. Honours a memory-ready handshake so slow memory stretches only the memory states.
- Reports illegal opcodes; fully combinational per-state decode lives inside, registered state only.

Parameters:
- OP_W, 6, opcode width.
- STATE_W, 4, state register width; must cover all states.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  OP_W  opcode from the IR, valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled only in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- branch  out  1  conditional PC load qualifier; PC enable = pc_write | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_req  out  1  memory access request.
- mem_write  out  1  write qualifier for mem_req.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.

Behaviour:
- Reset: state = FETCH asynchronously. The FETCH output pattern is held, but every write enable (ir_write, pc_write, reg_write, mem_req) is forced to 0 while rst_n = 0.
- Outputs are a pure function of the registered state, plus op in DECODE for illegal_op. Unlisted outputs are 0 in each state.
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States and transitions:
  - FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00. ir_write and pc_write assert only when mem_ready = 1. Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precomputes the branch target). Next state by op:
    - lw/sw -> MEMADR
    - R-type -> EXEC
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - any other opcode -> FETCH, with illegal_op = 1
  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state: lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req = 1, iord = 1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next state FETCH.
  - MEMWR: mem_req = 1, mem_write = 1, iord = 1. Hold until mem_ready, then go to FETCH.
  - EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state ALUWB.
  - ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, branch = 1, pc_src = 01. Next state FETCH.
  - ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDIWB.
  - ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
  - JUMP: pc_write = 1, pc_src = 10. Next state FETCH.
- Latency with mem_ready tied high:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - illegal opcode: 2 cycles.
  - Each low mem_ready cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready asserted outside a mem_req state is ignored.
- An unreachable state encoding recovers to FETCH on the next clock, with all enables 0 in that cycle.
- Reset asserted mid-instruction aborts immediately. No partial writes occur after rst_n falls.
- Implementation uses a unique case over state; no latches.

Optional Feature:
- MC_CTRL_BNE_EN defined:
  - Opcode 000101 (bne) is legal. DECODE -> BNEST.
  - BNEST matches BRANCH, except the PC enable qualifier uses ~zero. This is exported as extra output branch_ne: PC enable = pc_write | (branch & zero) | (branch_ne & ~zero).
  - bne latency is 3 cycles.
- MC_CTRL_BNE_EN undefined:
  - 000101 is illegal (illegal_op pulse, return to FETCH).
  - The branch_ne port is absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE)
  - enum state_t
  - alu_op, alu_src_b and pc_src encodings as typedef'd enums
- One sub-module is natural: mc_ctrl_outdec, a purely combinational state -> control-word decoder. mc_ctrl_fsm keeps only the state register and next-state logic.

Test Plan:
- Reset mid-MEMRD (rst_n low 2 cycles) -> state FETCH and all write enables 0 during reset; first fetch after release has ir_write = 1 and pc_write = 1 in the same cycle as mem_ready = 1.
- lw (op = 100011), mem_ready always 1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write = 1, mem_to_reg = 1 only in cycle 5.
- sw with mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, no state advance until mem_ready = 1, then FETCH.
- beq with zero = 1, then zero = 0 -> branch = 1, pc_src = 01 in cycle 3 both times; PC enable true only when zero = 1.
- R-type then addi -> EXEC alu_op = 10 / ALUWB reg_dst = 1; ADDIEX alu_src_b = 10 / ADDIWB reg_dst = 0; 4 cycles each.
- op = 111111 (and 000101 without MC_CTRL_BNE_EN) -> illegal_op pulses exactly 1 cycle in DECODE, FETCH next, no reg_write, pc_write or mem_req except in FETCH.
